// File: rtl/arq_ctrl.sv
// arq_ctrl: stop-and-wait ARQ sequencer that grants frames, waits for ACK/NAK,
// and schedules bounded retransmissions of the buffered frame.
module arq_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_arq_en,
   input  logic       i_retrans_en,
   input  logic       i_frame_req,
   input  logic       i_frame_done,
   input  logic       i_ack,
   input  logic       i_ack_seq,
   input  logic       i_nak,
   output logic       o_frame_grant,
   output logic       o_retrans,
   output logic       o_retrans_wait,
   output logic       o_seq,
   output logic       o_frame_ok,
   output logic       o_frame_drop,
   output logic [2:0] o_retry_cnt,
   output logic [2:0] o_state
);
   typedef enum logic [2:0] {IDLE = 3'd0, SEND = 3'd1, WAIT = 3'd2, RESEND = 3'd3} state_t;
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);
   state_t      state, state_nx;
   logic [15:0] timer, timer_nx;
   logic [2:0]  retry_nx;
   logic        seq_nx, grant_nx, retrans_nx, ok_nx, drop_nx, ack_hit, fail;
   assign ack_hit = i_ack && (i_ack_seq == o_seq);
   assign fail    = i_nak || (timer == TO_LAST);
   assign o_state = state;
   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      retry_nx   = o_retry_cnt;
      seq_nx     = o_seq;
      grant_nx   = 1'b0;
      retrans_nx = 1'b0;
      ok_nx      = 1'b0;
      drop_nx    = 1'b0;
      case (state)
         IDLE: if (i_frame_req) begin
            grant_nx = 1'b1;
            retry_nx = '0;
            state_nx = SEND;
         end
         SEND: if (i_frame_done) begin
            if (i_arq_en) begin
               timer_nx = '0;
               state_nx = WAIT;
            end else begin
               ok_nx    = 1'b1;
               seq_nx   = ~o_seq;
               state_nx = IDLE;
            end
         end
         WAIT: begin
            timer_nx = (timer == 16'hFFFF) ? timer : timer + 16'd1;
            // a matching ACK wins over a NAK or timeout in the same cycle
            if (ack_hit) begin
               ok_nx    = 1'b1;
               seq_nx   = ~o_seq;
               state_nx = IDLE;
            end else if (fail) begin
               if (o_retry_cnt == RETRY_MAX) begin
                  drop_nx  = 1'b1;
                  seq_nx   = ~o_seq;
                  state_nx = IDLE;
               end else begin
                  retry_nx = o_retry_cnt + 3'd1;
                  state_nx = RESEND;
               end
            end
         end
         RESEND: if (i_retrans_en) begin
            retrans_nx = 1'b1;
            state_nx   = SEND;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state          <= IDLE;
         timer          <= '0;
         o_frame_grant  <= 1'b0;
         o_retrans      <= 1'b0;
         o_retrans_wait <= 1'b0;
         o_seq          <= 1'b0;
         o_frame_ok     <= 1'b0;
         o_frame_drop   <= 1'b0;
         o_retry_cnt    <= '0;
      end else begin
         state          <= state_nx;
         timer          <= timer_nx;
         o_frame_grant  <= grant_nx;
         o_retrans      <= retrans_nx;
         o_retrans_wait <= (state_nx == WAIT) || (state_nx == RESEND);
         o_seq          <= seq_nx;
         o_frame_ok     <= ok_nx;
         o_frame_drop   <= drop_nx;
         o_retry_cnt    <= retry_nx;
      end
   end
endmodule
